// File: rtl/c17_arbiter_if.sv
// c17_arbiter_if: two-requester operand handshakes plus the single-entry result port.
interface c17_arbiter_if;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic out_valid, out_ready, out_id;
  logic [4:0] req0_data, req1_data;
  logic [1:0] out_data;
  modport master(
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_data
  );
  modport slave(
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_data
  );
endinterface

// File: rtl/c17_arbiter.sv
// c17_arbiter: round-robin arbiter feeding two requesters through a shared c17 datapath into a one-entry result buffer.
module c17_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  c17_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  logic rr, can_accept, gnt, gnt_id, n9, n10;
  logic [4:0] sel;
  logic [1:0] res;
  always_comb begin
    can_accept     = ~bus.out_valid | bus.out_ready;
    gnt            = ~rst & can_accept & (bus.req0_valid | bus.req1_valid);
    gnt_id         = (bus.req0_valid & bus.req1_valid) ? rr : bus.req1_valid;
    bus.req0_ready = gnt & ~gnt_id;
    bus.req1_ready = gnt & gnt_id;
    sel            = gnt_id ? bus.req1_data : bus.req0_data;
    n9             = sel[2] & sel[1];
    n10            = sel[3] & ~n9;
    res            = {(sel[4] & sel[2]) | n10, n10 | (sel[0] & ~n9)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_id    <= 1'b0;
      bus.out_data  <= 2'b00;
      rr            <= 1'b0;
      gnt_cnt0      <= '0;
      gnt_cnt1      <= '0;
    end else begin
      if (gnt) begin
        bus.out_valid <= 1'b1;
        bus.out_id    <= gnt_id;
        bus.out_data  <= res;
        rr            <= ~gnt_id;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (bus.req0_ready && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (bus.req1_ready && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_c17_arbiter.sv
// tb_c17_arbiter: vector table, directed corner sequences and a scoreboard for c17_arbiter.
module tb_c17_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cnt0, cnt1;
  logic [1:0] s_cnt0, s_cnt1;
  c17_arbiter_if b();
  c17_arbiter_if b2();
  c17_arbiter #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b.slave), .gnt_cnt0(cnt0), .gnt_cnt1(cnt1));
  c17_arbiter #(.CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(b2.slave), .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1));
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] d;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl[4];

  int errors = 0, checks = 0;
  int npush = 0, npop = 0, discarded = 0, acc0 = 0, acc1 = 0;
  logic [2:0] sb[$];
  logic p_hold = 1'b0;
  logic [2:0] p_out = 3'b000;

  // Reference written as the original c17 NAND netlist
  function automatic logic [1:0] c17(input logic [4:0] d);
    logic n10, n11, n16, n19;
    n10 = ~(d[4] & d[2]);
    n11 = ~(d[2] & d[1]);
    n16 = ~(d[3] & n11);
    n19 = ~(n11 & d[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    chk("rdy0_implies_valid", int'(b.req0_ready & ~b.req0_valid), 0);
    chk("rdy1_implies_valid", int'(b.req1_ready & ~b.req1_valid), 0);
    chk("rdy_exclusive", int'(b.req0_ready & b.req1_ready), 0);
    chk("gnt_cnt0", int'(cnt0), acc0);
    chk("gnt_cnt1", int'(cnt1), acc1);
    if (p_hold) begin
      chk("hold_valid", int'(b.out_valid), 1);
      chk("hold_out", int'({b.out_id, b.out_data}), int'(p_out));
    end
    if (rst) begin
      chk("rst_rdy", int'(b.req0_ready | b.req1_ready), 0);
      discarded += sb.size();
      sb.delete();
      acc0 = 0;
      acc1 = 0;
    end else begin
      if (b.out_valid && b.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got result %0d expected none", {b.out_id, b.out_data});
        end else begin
          e = sb.pop_front();
          npop++;
          chk("sb_result", int'({b.out_id, b.out_data}), int'(e));
        end
      end
      if (b.req0_ready) begin
        sb.push_back({1'b0, c17(b.req0_data)});
        npush++;
        if (acc0 < 255) acc0++;
      end
      if (b.req1_ready) begin
        sb.push_back({1'b1, c17(b.req1_data)});
        npush++;
        if (acc1 < 255) acc1++;
      end
    end
    p_hold = b.out_valid & ~b.out_ready & ~rst;
    p_out = {b.out_id, b.out_data};
  end

  initial begin
    tbl[0] = '{5'b11111, 2'b10};
    tbl[1] = '{5'b01000, 2'b11};
    tbl[2] = '{5'b00001, 2'b01};
    tbl[3] = '{5'b00000, 2'b00};
    {b.req0_valid, b.req1_valid, b.req0_data, b.req1_data} = '0;
    b.out_ready = 1'b1;
    {b2.req0_valid, b2.req1_valid, b2.req0_data, b2.req1_data} = '0;
    b2.out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", int'(b.out_valid), 0);
    chk("rst_out", int'({b.out_id, b.out_data}), 0);
    step();
    rst = 1'b0;
    // Sweep all operands through requester 0 at full throughput
    b.req0_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      b.req0_data = 5'(i);
      @(negedge clk);
      chk("sweep_ready", int'(b.req0_ready), 1);
      chk("sweep_out_valid", int'(b.out_valid), int'(i > 0));
      step();
    end
    b.req0_valid = 1'b0;
    step();
    // Known vectors through requester 1
    for (int i = 0; i < 4; i++) begin
      b.req1_valid = 1'b1;
      b.req1_data = tbl[i].d;
      step();
      b.req1_valid = 1'b0;
      @(negedge clk);
      chk("vec_valid", int'(b.out_valid), 1);
      chk("vec_id", int'(b.out_id), 1);
      chk("vec_data", int'(b.out_data), int'(tbl[i].exp));
      step();
    end
    // Contention after reset alternates starting with requester 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    b.req0_valid = 1'b1;
    b.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b.req0_data = 5'($urandom);
      b.req1_data = 5'($urandom);
      @(negedge clk);
      chk("cont_gnt0", int'(b.req0_ready), int'(i % 2 == 0));
      chk("cont_gnt1", int'(b.req1_ready), int'(i % 2 == 1));
      if (i > 0) chk("cont_id", int'(b.out_id), (i - 1) % 2);
      step();
    end
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    step();
    // Backpressure for three cycles, then drain and grant together
    b.req0_valid = 1'b1;
    b.req0_data = 5'b10101;
    step();
    b.req1_valid = 1'b1;
    b.req1_data = 5'b01010;
    b.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy", int'(b.req0_ready | b.req1_ready), 0);
      chk("bp_valid", int'(b.out_valid), 1);
      step();
    end
    b.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_gnt", int'(b.req0_ready | b.req1_ready), 1);
    step();
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", int'(b.out_valid), 1);
    step();
    step();
    // Reset while a result is held under backpressure
    b.req0_valid = 1'b1;
    step();
    b.out_ready = 1'b0;
    b.req1_valid = 1'b1;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", int'(b.req0_ready | b.req1_ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(b.out_valid), 0);
    chk("mid_rst_cnt", int'(cnt0) + int'(cnt1), 0);
    chk("mid_rst_first0", int'(b.req0_ready), 1);
    chk("mid_rst_first1", int'(b.req1_ready), 0);
    step();
    b.out_ready = 1'b1;
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    step();
    step();
    // Random traffic, checked by the scoreboard and protocol monitor
    for (int i = 0; i < 200; i++) begin
      b.req0_valid = 1'($urandom);
      b.req1_valid = 1'($urandom);
      b.req0_data = 5'($urandom);
      b.req1_data = 5'($urandom);
      b.out_ready = ($urandom_range(3) != 0);
      step();
    end
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    b.out_ready = 1'b1;
    step();
    step();
    step();
    // Counter saturation with a 2-bit counter
    b2.req1_valid = 1'b1;
    b2.req1_data = 5'b11111;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("sat_cnt1", int'(s_cnt1), k > 3 ? 3 : k);
    end
    b2.req1_valid = 1'b0;
    step();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("result_count", npop, npush - discarded);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
